// File: rtl/mm_outer_loop_ctrl.sv
// mm_outer_loop_ctrl
//   Outer-loop sequencer for the wide Montgomery multiply. It latches operand B,
//   slices it into RADIX-bit digits and issues one inner-loop enable per digit.
//   Each digit is held on bi until the inner loop reports done. The accumulator
//   is then strobed, and the controller moves on to the next digit.
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : begin one outer pass (sampled only while idle)
//   abort       : synchronous cancel of the current pass
//   b           : SIZE+2 bit multiplier operand, captured on accepted start
//   bi          : current digit to the inner loop (registered)
//   il_en       : one-cycle enable pulse to the inner loop
//   il_done     : inner-loop completion
//   acc_en      : one-cycle accumulate strobe
//   digit_idx   : index of the digit in flight
//   busy        : high whenever not idle
//   done        : one-cycle pulse after the last digit's acc_en
//   err         : one-cycle watchdog timeout pulse
//
// Optional feature macro: MM_OUTER_WDOG_EN (WAIT-state watchdog; err is 0 without it)
module mm_outer_loop_ctrl #(
  parameter int SIZE    = 3072,
  parameter int RADIX   = 78,
  parameter int DIGITS  = 40,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [SIZE+1:0]    b,
  output logic [RADIX-1:0]   bi,
  output logic               il_en,
  input  logic               il_done,
  output logic               acc_en,
  output logic [CNT_W-1:0]   digit_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int BW = SIZE + 2;
  localparam int RW = DIGITS * RADIX;

  // Elaboration-time sanity check of the configuration.
  if (((1 << CNT_W) < DIGITS) || (RW < BW) || (TIMEOUT < 2) || (TIMEOUT > 15)) begin : g_bad_cfg
    $error("mm_outer_loop_ctrl: invalid parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [RW-1:0]    r_b;
  logic [RADIX-1:0] r_bi;
  logic [CNT_W-1:0] r_idx;
  logic             r_il_en;
  logic             r_acc_en;
  logic             r_done;
  logic             r_err;
  logic             w_last;

`ifdef MM_OUTER_WDOG_EN
  logic [3:0]       r_wd;
  logic [3:0]       w_wd_next;
  assign w_wd_next = r_wd + 4'd1;
`endif

  assign w_last = (r_idx == CNT_W'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_b      <= '0;
      r_bi     <= '0;
      r_idx    <= '0;
      r_il_en  <= 1'b0;
      r_acc_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef MM_OUTER_WDOG_EN
      r_wd     <= '0;
`endif
    end else begin
      r_il_en  <= 1'b0;
      r_acc_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_b     <= {{(RW - BW){1'b0}}, b};
            r_bi    <= b[RADIX-1:0];
            r_idx   <= '0;
            r_il_en <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // il_done here is ignored: the inner loop cannot finish in 0 cycles.
          if (abort) begin
            r_bi    <= '0;
            r_state <= S_IDLE;
          end else begin
`ifdef MM_OUTER_WDOG_EN
            // Timer counts the il_en cycle itself, so err lands TIMEOUT cycles after il_en.
            r_wd    <= 4'd1;
`endif
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            r_bi    <= '0;
            r_state <= S_IDLE;
          end else if (il_done) begin
            r_acc_en <= 1'b1;
            r_state  <= S_ACC;
`ifdef MM_OUTER_WDOG_EN
          end else if (w_wd_next == 4'(TIMEOUT)) begin
            r_err   <= 1'b1;
            r_bi    <= '0;
            r_state <= S_IDLE;
          end else begin
            r_wd    <= w_wd_next;
`endif
          end
        end
        S_ACC: begin
          if (abort) begin
            r_bi    <= '0;
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_b     <= r_b >> RADIX;
            r_bi    <= r_b[2*RADIX-1:RADIX];
            r_idx   <= r_idx + 1'b1;
            r_il_en <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_FIN: begin
          r_bi    <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bi        = r_bi;
  assign il_en     = r_il_en;
  assign acc_en    = r_acc_en;
  assign digit_idx = r_idx;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mm_outer_loop_ctrl.sv
// tb_mm_outer_loop_ctrl
//   Directed self-checking bench for mm_outer_loop_ctrl at default parameters.
//   Inputs are driven and outputs observed on the falling clock edge.
module tb_mm_outer_loop_ctrl;

  localparam int SZ = 3074;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          il_done = 1'b0;
  logic [SZ-1:0] b = '0;
  logic [77:0]   bi;
  logic          il_en;
  logic          acc_en;
  logic [5:0]    digit_idx;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;

  mm_outer_loop_ctrl #(
    .SIZE(3072),
    .RADIX(78),
    .DIGITS(40),
    .CNT_W(6),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .b(b),
    .bi(bi),
    .il_en(il_en),
    .il_done(il_done),
    .acc_en(acc_en),
    .digit_idx(digit_idx),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-derived digit values for each operand pattern.
  function automatic logic [77:0] hand_digit(input int pat, input int k);
    case (pat)
      0:       return (k == 0) ? 78'd1 : 78'd0;
      1:       return (k < 39) ? 78'h3FFF_FFFF_FFFF_FFFF_FFFF : 78'hFFFF_FFFF;
      default: return 78'(k + 1);
    endcase
  endfunction

  function automatic logic [SZ-1:0] make_b(input int pat);
    logic [SZ-1:0] v;
    v = '0;
    case (pat)
      0: v[0] = 1'b1;
      1: v = '1;
      default: begin
        for (int k = 0; k < 39; k++) v[78*k +: 78] = 78'(k + 1);
        v[3042 +: 32] = 32'd40;
      end
    endcase
    return v;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_bi"}, bi, 0);
    check({pfx, "_il_en"}, il_en, 0);
    check({pfx, "_acc_en"}, acc_en, 0);
    check({pfx, "_idx"}, digit_idx, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_err"}, err, 0);
  endtask

  // One outer pass with an inline inner-loop responder.
  // var_dly: random 1..10 cycle responses; *_k: digit at which to inject an event (-1 = none).
  task automatic run_pass(input int pat, input bit var_dly, input int spur_k,
                          input int abort_k, input int start_k, input int rst_k);
    int cyc, nen, nacc, cnt, last_done;
    bit outst, fin, aborted, was_reset;
    logic [77:0] hbi;
    logic [5:0]  hidx;
    cyc = 0; nen = 0; nacc = 0; cnt = 0; last_done = -10;
    outst = 0; fin = 0; aborted = 0; was_reset = 0;
    hbi = '0; hidx = '0;
    @(negedge clk);
    b = make_b(pat);
    start = 1'b1;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      il_done = 1'b0;
      abort = 1'b0;
      if (aborted) begin
        check("abort_acc_en", acc_en, 0);
        check("abort_busy", busy, 0);
        check("abort_bi", bi, 0);
        check("abort_done", done, 0);
        fin = 1;
      end else begin
        check("busy_in_pass", busy, 1);
        if (acc_en) begin
          check("acc_after_done", cyc, last_done + 1);
          nacc++;
        end
        if (il_en) begin
          check("one_outstanding", outst, 0);
          check("bi_digit", bi, hand_digit(pat, nen));
          check("idx_at_en", digit_idx, nen);
          if (!var_dly) check("il_en_cycle", cyc, 1 + 6 * nen);
          outst = 1;
          hbi = bi;
          hidx = digit_idx;
          cnt = var_dly ? int'($urandom_range(1, 10)) : 4;
          if (nen == spur_k) il_done = 1'b1;
          if (nen == start_k) begin
            start = 1'b1;
            b = '1;
          end
          nen++;
        end else if (outst) begin
          check("bi_hold", bi, hbi);
          check("idx_hold", digit_idx, hidx);
          cnt--;
          if (nen - 1 == rst_k && cnt == 2) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("async_rst");
            was_reset = 1;
            fin = 1;
          end else if (cnt == 0) begin
            il_done = 1'b1;
            outst = 0;
            last_done = cyc;
            if (nen - 1 == abort_k) begin
              abort = 1'b1;
              aborted = 1;
            end
          end
        end
        if (done) begin
          if (!var_dly) check("done_cycle", cyc, 241);
          check("acc_count", nacc, 40);
          check("en_count", nen, 40);
          fin = 1;
        end
      end
    end
    if (!fin) check("pass_timeout", 0, 1);
    if (was_reset) begin
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      il_done = 1'b1;
      @(negedge clk);
      il_done = 1'b0;
      check("stale_done_acc", acc_en, 0);
      check("stale_done_busy", busy, 0);
    end else if (!aborted) begin
      @(negedge clk);
      check("post_busy", busy, 0);
      check("post_done", done, 0);
      check("post_bi", bi, 0);
    end
  endtask

  initial begin
    int errs;
    int en_cyc;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("after_reset");

    run_pass(0, 1'b0, -1, -1, -1, -1);  // b = 1, fixed 4-cycle responder
    run_pass(1, 1'b0, -1, -1, -1, -1);  // b = all ones
    run_pass(2, 1'b1, 3, -1, -1, -1);   // variable delays, il_done during ISSUE at digit 3
    run_pass(0, 1'b0, -1, 7, -1, -1);   // abort with il_done at digit 7
    run_pass(2, 1'b0, -1, -1, 12, -1);  // new pass from digit 0, stray start at digit 12
    run_pass(2, 1'b0, -1, -1, -1, 20);  // async reset at digit 20

    // Withheld il_done: watchdog behaviour.
    @(negedge clk);
    b = make_b(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    en_cyc = 1;
    check("wd_il_en", il_en, 1);
    errs = 0;
`ifdef MM_OUTER_WDOG_EN
    for (int c = en_cyc + 1; c <= en_cyc + 20; c++) begin
      @(negedge clk);
      check("wd_no_acc", acc_en, 0);
      if (err) begin
        errs++;
        check("wd_err_cycle", c, en_cyc + 15);
        check("wd_err_busy", busy, 0);
        check("wd_err_done", done, 0);
      end
    end
    check("wd_err_count", errs, 1);
`else
    for (int c = en_cyc + 1; c <= en_cyc + 30; c++) begin
      @(negedge clk);
      if (err) errs++;
      check("wd_still_busy", busy, 1);
    end
    check("wd_err_count", errs, 0);
    check("wd_idx", digit_idx, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("wd_abort_busy", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
